key_scheduler: RTL and testbench

KEY_SCHEDULER -- requirements
Module: key_scheduler

---
 rtl/key_scheduler.sv | 141 ++++++++++++++
 tb/tb_key_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/key_scheduler.sv
// rtl/key_scheduler.sv - RC4 key-scheduling (KSA) sequencer driving a 256x8 S-memory.
// Optional identity fill state compiled in with KEY_SCHEDULER_INIT_EN.
module key_scheduler #(
    parameter int KEY_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [KEY_WIDTH-1:0] key,
    output logic                 busy,
    output logic                 finished,
    output logic [7:0]           address,
    output logic [7:0]           data,
    output logic                 wren,
    input  logic [7:0]           q
);

    localparam int KB  = KEY_WIDTH / 8;
    localparam int KIW = (KB > 1) ? $clog2(KB) : 1;
    localparam logic [KIW-1:0] KIDX_LAST = KIW'(KB - 1);

    typedef enum logic [3:0] {
        IDLE, INIT, RD_I, LD_I, RD_J, LD_J, WR_I, WR_J, DONE
    } state_t;

    state_t               state;
    logic [KEY_WIDTH-1:0] key_reg;
    logic [7:0]           i;
    logic [7:0]           j;
    logic [7:0]           si;
    logic [KIW-1:0]       kidx;
    logic [KEY_WIDTH-1:0] key_shift;
    logic [7:0]           key_byte;
    logic [7:0]           j_sum;

    // kidx tracks i mod KB so no divider is needed; shifting brings that byte to the top.
    always_comb begin
        key_shift = key_reg << {kidx, 3'b000};
        key_byte  = key_shift[KEY_WIDTH-1 -: 8];
        j_sum     = j + q + key_byte;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            key_reg  <= '0;
            i        <= '0;
            j        <= '0;
            si       <= '0;
            kidx     <= '0;
            busy     <= 1'b0;
            finished <= 1'b0;
            address  <= '0;
            data     <= '0;
            wren     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        key_reg <= key;
                        i       <= '0;
                        j       <= '0;
                        kidx    <= '0;
                        busy    <= 1'b1;
                        address <= '0;
                        data    <= '0;
`ifdef KEY_SCHEDULER_INIT_EN
                        wren    <= 1'b1;
                        state   <= INIT;
`else
                        wren    <= 1'b0;
                        state   <= RD_I;
`endif
                    end
                end
`ifdef KEY_SCHEDULER_INIT_EN
                INIT: begin
                    if (i == 8'hFF) begin
                        i       <= '0;
                        address <= '0;
                        wren    <= 1'b0;
                        state   <= RD_I;
                    end else begin
                        i       <= i + 8'd1;
                        address <= i + 8'd1;
                        data    <= i + 8'd1;
                    end
                end
`endif
                RD_I: begin
                    state <= LD_I;
                end
                LD_I: begin
                    si      <= q;
                    j       <= j_sum;
                    address <= j_sum;
                    state   <= RD_J;
                end
                RD_J: begin
                    state <= LD_J;
                end
                // The data register doubles as the sj latch for the WR_I write.
                LD_J: begin
                    data    <= q;
                    address <= i;
                    wren    <= 1'b1;
                    state   <= WR_I;
                end
                WR_I: begin
                    address <= j;
                    data    <= si;
                    state   <= WR_J;
                end
                WR_J: begin
                    wren <= 1'b0;
                    if (i == 8'hFF) begin
                        finished <= 1'b1;
                        state    <= DONE;
                    end else begin
                        i       <= i + 8'd1;
                        address <= i + 8'd1;
                        kidx    <= (kidx == KIDX_LAST) ? '0 : kidx + 1'b1;
                        state   <= RD_I;
                    end
                end
                DONE: begin
                    finished <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    wren     <= 1'b0;
                    busy     <= 1'b0;
                    finished <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_scheduler.sv
// tb/tb_key_scheduler.sv - randomized KSA runs against a software RC4 model and S-memory model.
// Honours KEY_SCHEDULER_INIT_EN for latency and identity-fill expectations.
module tb_key_scheduler;

    localparam int KW = 24;
    localparam int KB = KW / 8;
`ifdef KEY_SCHEDULER_INIT_EN
    localparam int LAT = 1793;
    localparam int OFF = 256;
`else
    localparam int LAT = 1537;
    localparam int OFF = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [KW-1:0] key;
    logic          busy;
    logic          finished;
    logic [7:0]    address;
    logic [7:0]    data;
    logic          wren;
    logic [7:0]    q;

    logic [7:0] mem [256];
    logic       do_fill;
    logic [7:0] fill_xor;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int         cyc;
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;
    wr_t wlog[$];

    key_scheduler #(.KEY_WIDTH(KW)) dut (
        .clk(clk), .reset(reset), .start(start), .key(key),
        .busy(busy), .finished(finished), .address(address),
        .data(data), .wren(wren), .q(q)
    );

    always #5 clk = ~clk;

    // Synchronous-read S-memory with one-cycle read latency.
    always @(posedge clk) begin
        if (do_fill) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k) ^ fill_xor;
        end else if (wren) begin
            mem[address] <= data;
        end
        q <= mem[address];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] kbyte(input logic [KW-1:0] k, input int idx);
        logic [KW-1:0] t;
        t = k >> (8 * (KB - 1 - (idx % KB)));
        return t[7:0];
    endfunction

    task automatic ksa_model(input logic [KW-1:0] k, output logic [7:0] s [256]);
        int jj;
        logic [7:0] t;
        for (int n = 0; n < 256; n++) s[n] = 8'(n);
        jj = 0;
        for (int n = 0; n < 256; n++) begin
            jj = (jj + int'(s[n]) + int'(kbyte(k, n))) % 256;
            t = s[n]; s[n] = s[jj]; s[jj] = t;
        end
    endtask

    task automatic prep_mem(input logic [7:0] x);
        @(negedge clk);
        fill_xor = x;
        do_fill  = 1'b1;
        @(negedge clk);
        do_fill  = 1'b0;
    endtask

    // Runs one schedule; mid_at pulses start with a new key, abort_at asserts reset.
    task automatic run(input string tag, input logic [KW-1:0] k, input int mid_at, input int abort_at);
        logic [7:0] s_exp [256];
        logic [7:0] j1;
        int fin_cyc, fin_cnt, busy_low, bad, nwr;
        fin_cyc = -1; fin_cnt = 0; busy_low = 0; bad = 0;
        wlog.delete();
`ifdef KEY_SCHEDULER_INIT_EN
        prep_mem(8'h5A);
`else
        prep_mem(8'h00);
`endif
        key = k;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        key = KW'($urandom);
        for (int cyc = 1; cyc <= LAT + 20; cyc++) begin
            @(negedge clk);
            if (wren) wlog.push_back('{cyc, address, data});
            if (finished) begin
                fin_cnt++;
                if (fin_cyc < 0) fin_cyc = cyc;
            end
            if (cyc <= LAT && !busy) busy_low++;
            if (cyc == mid_at) begin
                start = 1'b1;
                key = KW'($urandom);
            end
            if (cyc == mid_at + 1) start = 1'b0;
            if (cyc == abort_at) reset = 1'b1;
            if (cyc == abort_at + 1) begin
                reset = 1'b0;
                check({tag, " abort busy"}, busy, 0);
                check({tag, " abort wren"}, wren, 0);
                check({tag, " abort finished"}, finished, 0);
                check({tag, " abort address"}, address, 0);
                nwr = wlog.size();
                repeat (5) begin
                    @(negedge clk);
                    if (wren) wlog.push_back('{0, address, data});
                end
                check({tag, " abort no writes"}, wlog.size(), nwr);
                return;
            end
        end
        ksa_model(k, s_exp);
        check({tag, " finished cycle"}, fin_cyc, LAT);
        check({tag, " finished pulses"}, fin_cnt, 1);
        check({tag, " busy low"}, busy_low, 0);
        check({tag, " idle busy"}, busy, 0);
        check({tag, " write count"}, wlog.size(), OFF + 512);
`ifdef KEY_SCHEDULER_INIT_EN
        for (int n = 0; n < 256; n++)
            if (wlog[n].cyc != n + 1 || wlog[n].a != 8'(n) || wlog[n].d != 8'(n)) bad++;
        check({tag, " init writes"}, bad, 0);
        bad = 0;
`endif
        j1 = kbyte(k, 0);
        if (wlog.size() >= OFF + 2) begin
            check({tag, " swap0 i addr"}, wlog[OFF].a, 8'h00);
            check({tag, " swap0 i data"}, wlog[OFF].d, j1);
            check({tag, " swap0 j addr"}, wlog[OFF+1].a, j1);
            check({tag, " swap0 j data"}, wlog[OFF+1].d, 8'h00);
        end
        for (int n = 0; n < 256; n++) if (mem[n] !== s_exp[n]) bad++;
        check({tag, " memory"}, bad, 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        key = '0;
        do_fill = 1'b0;
        fill_xor = 8'h00;
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("reset busy", busy, 0);
        check("reset finished", finished, 0);
        check("reset wren", wren, 0);
        check("reset address", address, 0);
        check("reset data", data, 0);
        repeat (3) @(negedge clk);
        check("idle no start", busy, 0);

        run("k010203", 24'h010203, -1, -1);
        run("kFF0000", 24'hFF0000, -1, -1);
        run("k000000", 24'h000000, -1, -1);
        run("midstart", KW'($urandom), 500, -1);
        run("abort", KW'($urandom), -1, 1000);
        run("after abort", KW'($urandom), -1, -1);
        for (int r = 0; r < 3; r++) run("random", KW'($urandom), -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
